// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: lets several byte-level SPI clients share one generic_spi_master
// and its chip select. Ownership lasts a whole chip-select transaction and is granted
// round-robin. spi_cs_n gets a one-cycle setup before the first byte and a minimum
// deselect gap after release.
// Ports:
//   clk, reset       system clock (sysclk), synchronous active-high reset
//   m_sel/m_req/m_d  per-client transaction request, byte request, transmit byte
//   m_ack            one-cycle byte-done pulse to the owner
//   m_q              received byte, broadcast to all clients
//   m_gnt            one-hot ownership indication (registered)
//   s_req/s_d        byte request and transmit byte to the SPI master
//   s_ack/s_q        byte-done pulse and received byte from the SPI master
//   spi_cs_n         device chip select, active low (registered)
module spi_bus_arbiter #(
  parameter int unsigned masters = 2,
  parameter int unsigned dbits   = 8,
  parameter int unsigned cs_gap  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [masters-1:0]       m_sel,
  input  logic [masters-1:0]       m_req,
  output logic [masters-1:0]       m_ack,
  input  logic [masters*dbits-1:0] m_d,
  output logic [dbits-1:0]         m_q,
  output logic [masters-1:0]       m_gnt,
  output logic                     s_req,
  input  logic                     s_ack,
  output logic [dbits-1:0]         s_d,
  input  logic [dbits-1:0]         s_q,
  output logic                     spi_cs_n
);

  localparam int unsigned ow      = (masters > 1) ? $clog2(masters) : 1;
  localparam int unsigned sw      = ow + 1;
  localparam int unsigned gap_len = (cs_gap == 0) ? 1 : cs_gap;
  localparam int unsigned gw      = $clog2(gap_len + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_GAP
  } state_t;

  state_t           state, state_nx;
  logic [ow-1:0]    owner, owner_nx;
  logic [ow-1:0]    last, last_nx;
  logic [gw-1:0]    gap_cnt, gap_nx;
  logic             cs_n_nx;
  logic [masters-1:0] gnt_nx;

  logic [ow-1:0]    pick;
  logic             pick_vld;
  logic [sw-1:0]    cand;

  // Per-client transmit byte view
  logic [dbits-1:0] d_arr [masters];
  for (genvar i = 0; i < masters; i++) begin : g_slice
    assign d_arr[i] = m_d[i*dbits +: dbits];
  end

  // Round-robin pick: first m_sel bit searching from last+1 upward, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= masters; i++) begin
      cand = {1'b0, last} + sw'(i);
      if (cand >= sw'(masters)) cand = cand - sw'(masters);
      if (!pick_vld && m_sel[cand[ow-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[ow-1:0];
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= '0;
      last     <= ow'(masters - 1);
      gap_cnt  <= '0;
      spi_cs_n <= 1'b1;
      m_gnt    <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last     <= last_nx;
      gap_cnt  <= gap_nx;
      spi_cs_n <= cs_n_nx;
      m_gnt    <= gnt_nx;
    end
  end

  // Next state; the owner keeps the bus until both its sel and req are low,
  // so a byte in flight when sel drops still completes under chip select
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    gap_nx   = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_nx = pick;
          last_nx  = pick;
          state_nx = ST_SETUP;
        end
      end
      ST_SETUP: state_nx = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!m_sel[owner] && !m_req[owner]) begin
          state_nx = ST_GAP;
          gap_nx   = gw'(gap_len);
        end
      end
      ST_GAP: begin
        if (gap_cnt <= gw'(1)) begin
          state_nx = ST_IDLE;
          gap_nx   = '0;
        end else begin
          gap_nx = gap_cnt - gw'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Chip select and grant are decoded from the next state so they register in step with it
  always_comb begin
    cs_n_nx = 1'b1;
    gnt_nx  = '0;
    if (state_nx == ST_SETUP || state_nx == ST_ACTIVE) begin
      cs_n_nx          = 1'b0;
      gnt_nx[owner_nx] = 1'b1;
    end
  end

  // Zero-latency byte path between the owner and the SPI master
  always_comb begin
    s_req = 1'b0;
    s_d   = d_arr[owner];
    m_ack = '0;
    if (state == ST_ACTIVE) begin
      s_req        = m_req[owner];
      m_ack[owner] = s_ack;
    end
  end

  assign m_q = s_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: two instances (cs_gap=4 and cs_gap=0), a randomised SPI
// master stand-in, client driver tasks and a monitor holding the round-robin reference.
module tb_spi_bus_arbiter;

  localparam int unsigned MASTERS = 2;
  localparam int unsigned DBITS   = 8;
  localparam int unsigned GEFF_A  = 4;   // effective gap of instance A (cs_gap=4)
  localparam int unsigned GEFF_B  = 1;   // effective gap of instance B (cs_gap=0)

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic                     reset;
  logic [MASTERS-1:0]       m_sel, m_req, m_ack, m_gnt;
  logic [MASTERS*DBITS-1:0] m_d;
  logic [DBITS-1:0]         m_q, s_d, s_q;
  logic                     s_req, s_ack, spi_cs_n;

  logic [MASTERS-1:0]       b_sel, b_req, b_ack, b_gnt;
  logic [MASTERS*DBITS-1:0] b_d;
  logic [DBITS-1:0]         b_q, b_sd, b_sq;
  logic                     b_sreq, b_sack, b_cs_n;

  spi_bus_arbiter #(.masters(MASTERS), .dbits(DBITS), .cs_gap(4)) dut_a (
    .clk(sysclk), .reset(reset), .m_sel(m_sel), .m_req(m_req), .m_ack(m_ack),
    .m_d(m_d), .m_q(m_q), .m_gnt(m_gnt), .s_req(s_req), .s_ack(s_ack),
    .s_d(s_d), .s_q(s_q), .spi_cs_n(spi_cs_n));

  spi_bus_arbiter #(.masters(MASTERS), .dbits(DBITS), .cs_gap(0)) dut_b (
    .clk(sysclk), .reset(reset), .m_sel(b_sel), .m_req(b_req), .m_ack(b_ack),
    .m_d(b_d), .m_q(b_q), .m_gnt(b_gnt), .s_req(b_sreq), .s_ack(b_sack),
    .s_d(b_sd), .s_q(b_sq), .spi_cs_n(b_cs_n));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // SPI master stand-in and scoreboard of bytes it exchanged
  bit         slave_en    = 1'b1;
  int         slave_delay = -1;
  logic [7:0] rx_plan[$];
  logic [7:0] tx_plan[$];
  logic [7:0] sb_tx[$];
  logic [7:0] sb_rx[$];
  logic [7:0] rcv_q[$];

  initial begin
    s_ack = 1'b0;
    s_q   = '0;
    forever begin
      tick();
      if (slave_en && s_req && !s_ack) begin
        logic [7:0] tx, rx;
        int d;
        tx = s_d;
        d  = (slave_delay < 0) ? int'($urandom_range(0, 2)) : slave_delay;
        repeat (d) @(posedge sysclk);
        @(negedge sysclk);
        rx = (rx_plan.size() > 0) ? rx_plan.pop_front() : 8'($urandom);
        s_q   = rx;
        s_ack = 1'b1;
        sb_tx.push_back(tx);
        sb_rx.push_back(rx);
        @(negedge sysclk);
        s_ack = 1'b0;
      end
    end
  end

  // Monitor: round-robin reference, byte-path rules, chip-select gap
  int   mdl_last = MASTERS - 1;
  int   grant_log[$];
  int   run = 0, last_run = 0;
  bit   seen_low = 1'b0;
  int   err_gnt = 0, err_sreq = 0, err_ack = 0, err_gap = 0, err_q = 0;
  int   ack_cnt0 = 0, ack_cnt1 = 0;
  int   gnt_age = 0;
  logic [MASTERS-1:0] gnt_prev = '0;
  logic [MASTERS-1:0] sel_s;
  logic rst_s;

  always begin
    int exp_w, j;
    logic gsel, exp_sreq;
    logic [MASTERS-1:0] exp_ack;
    @(posedge sysclk);
    sel_s = m_sel;
    rst_s = reset;
    #1;
    if (rst_s) begin
      mdl_last = MASTERS - 1;
      seen_low = 1'b0;
      run      = 0;
      gnt_prev = '0;
      gnt_age  = 0;
    end else begin
      gsel = m_gnt[1];
      if (((m_gnt != 2'b00) != (spi_cs_n == 1'b0)) || !$onehot0(m_gnt)) err_gnt++;
      if (gnt_prev == 2'b00 && m_gnt != 2'b00) begin
        exp_w = -1;
        for (int k = 1; k <= int'(MASTERS); k++) begin
          j = (mdl_last + k) % MASTERS;
          if (exp_w < 0 && ((sel_s >> j) & 2'b01) != 2'b00) exp_w = j;
        end
        check("rr_grant", 32'(gsel), 32'(exp_w));
        grant_log.push_back(int'(gsel));
        if (exp_w >= 0) mdl_last = exp_w;
        gnt_age = 0;
      end else if (m_gnt != 2'b00) begin
        gnt_age++;
      end else begin
        gnt_age = 0;
      end
      // byte path is open only after the setup cycle
      exp_sreq = (m_gnt != 2'b00 && gnt_age >= 1) ? m_req[gsel] : 1'b0;
      if (s_req !== exp_sreq) err_sreq++;
      if (s_req && s_d !== (gsel ? m_d[15:8] : m_d[7:0])) err_sreq++;
      exp_ack = (m_gnt != 2'b00 && gnt_age >= 1 && s_ack) ? m_gnt : 2'b00;
      if (m_ack !== exp_ack) err_ack++;
      if (m_q !== s_q) err_q++;
      ack_cnt0 += int'(m_ack[0]);
      ack_cnt1 += int'(m_ack[1]);
      if (spi_cs_n) run++;
      else begin
        if (run > 0 && seen_low) begin
          last_run = run;
          if (run < int'(GEFF_A) + 1) err_gap++;
        end
        run      = 0;
        seen_low = 1'b1;
      end
      gnt_prev = m_gnt;
    end
  end

  int gnt_wait = 0;

  // One client transaction of n bytes on instance A
  task automatic client_txn(input logic ci, input int n);
    int t;
    logic [7:0] b, qv;
    @(negedge sysclk);
    m_sel[ci] = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!m_gnt[ci] && t < 400);
    gnt_wait = t;
    check("gnt_bound", 32'(m_gnt[ci]), 32'(1));
    if (m_gnt[ci]) begin
      for (int k = 0; k < n; k++) begin
        @(negedge sysclk);
        b = (!ci && tx_plan.size() > 0) ? tx_plan.pop_front() : 8'($urandom);
        if (ci) m_d[15:8] = b; else m_d[7:0] = b;
        m_req[ci] = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!m_ack[ci] && t < 50);
        check("ack_bound", 32'(m_ack[ci]), 32'(1));
        if (m_ack[ci]) begin
          qv = m_q;
          rcv_q.push_back(qv);
          if (sb_rx.size() == 0) check("sb_empty", 32'(0), 32'(1));
          else begin
            check("tx_byte", 32'(sb_tx.pop_front()), 32'(b));
            check("rx_byte", 32'(qv), 32'(sb_rx.pop_front()));
          end
        end
      end
    end
    @(negedge sysclk);
    m_req[ci] = 1'b0;
    m_sel[ci] = 1'b0;
  endtask

  function automatic int log_at(input int k);
    return (grant_log.size() > k) ? grant_log[k] : -1;
  endfunction

  initial begin
    int t, hi, cs_hi, base0, base1;
    reset = 1'b1;
    m_sel = '0; m_req = '0; m_d = '0;
    b_sel = '0; b_req = '0; b_d = '0; b_sack = 1'b0; b_sq = '0;
    repeat (3) @(negedge sysclk);
    check("rst_cs_n", 32'(spi_cs_n), 32'(1));
    check("rst_gnt",  32'(m_gnt), 32'(0));
    check("rst_sreq", 32'(s_req), 32'(0));
    check("rst_ack",  32'(m_ack), 32'(0));
    reset = 1'b0;

    // single client, fixed bytes
    tx_plan = '{8'h9F, 8'h00, 8'h00};
    rx_plan = '{8'hEF, 8'h40, 8'h18};
    rcv_q.delete();
    base0 = ack_cnt0;
    client_txn(1'b0, 3);
    check("t1_gnt_lat", 32'(gnt_wait), 32'(1));
    check("t1_acks", 32'(ack_cnt0 - base0), 32'(3));
    check("t1_rx0", 32'((rcv_q.size() > 0) ? rcv_q[0] : 8'hxx), 32'(8'hEF));
    check("t1_rx1", 32'((rcv_q.size() > 1) ? rcv_q[1] : 8'hxx), 32'(8'h40));
    check("t1_rx2", 32'((rcv_q.size() > 2) ? rcv_q[2] : 8'hxx), 32'(8'h18));
    hi = 0;
    repeat (GEFF_A + 1) begin tick(); if (spi_cs_n) hi++; end
    check("t1_gap_hi", 32'(hi), 32'(GEFF_A + 1));

    // simultaneous requests out of reset: order 0,1,0
    @(negedge sysclk); reset = 1'b1;
    @(negedge sysclk); reset = 1'b0;
    grant_log.delete();
    fork
      begin client_txn(1'b0, 1); client_txn(1'b0, 1); end
      client_txn(1'b1, 2);
    join
    check("t2_n_grants", 32'(grant_log.size()), 32'(3));
    check("t2_order0", 32'(log_at(0)), 32'(0));
    check("t2_order1", 32'(log_at(1)), 32'(1));
    check("t2_order2", 32'(log_at(2)), 32'(0));
    check("t2_gap_exact", 32'(last_run), 32'(GEFF_A + 1));

    // non-owner m_req is ignored
    base1 = ack_cnt1;
    fork
      client_txn(1'b0, 2);
      begin @(negedge sysclk); m_d[15:8] = 8'hA5; m_req[1] = 1'b1; end
    join
    @(negedge sysclk); m_req[1] = 1'b0;
    check("t3_nonowner_ack", 32'(ack_cnt1 - base1), 32'(0));

    // owner drops m_sel with a byte in flight
    repeat (GEFF_A + 2) @(negedge sysclk);
    slave_delay = 3;
    m_sel[0] = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!m_gnt[0] && t < 50);
    @(negedge sysclk); m_d[7:0] = 8'h5A; m_req[0] = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!s_req && t < 50);
    check("t4_sreq_seen", 32'(s_req), 32'(1));
    @(negedge sysclk); m_sel[0] = 1'b0;
    t = 0; cs_hi = 0;
    do begin tick(); t++; if (spi_cs_n) cs_hi++; end while (!m_ack[0] && t < 50);
    check("t4_cs_held", 32'(cs_hi), 32'(0));
    check("t4_ack", 32'(m_ack[0]), 32'(1));
    if (sb_tx.size() > 0) begin
      check("t4_tx", 32'(sb_tx.pop_front()), 32'(8'h5A));
      check("t4_rx", 32'(m_q), 32'(sb_rx.pop_front()));
    end else check("t4_sb", 32'(0), 32'(1));
    @(negedge sysclk); m_req[0] = 1'b0;
    tick();
    check("t4_cs_rise", 32'(spi_cs_n), 32'(1));
    slave_delay = -1;

    // cs_gap=0 instance: chip select high between back-to-back owners
    @(negedge sysclk); b_sel = 2'b11;
    t = 0;
    do begin tick(); t++; end while (!b_gnt[0] && t < 20);
    @(negedge sysclk); b_sel[0] = 1'b0;
    t = 0;
    do begin tick(); t++; end while (!b_cs_n && t < 20);
    hi = 0;
    while (b_cs_n && hi < 20) begin hi++; tick(); end
    check("t5_gap0_hi", 32'(hi), 32'(GEFF_B + 1));
    check("t5_gnt1", 32'(b_gnt), 32'(2'b10));
    @(negedge sysclk); b_sel = '0;

    // reset while ACTIVE with s_req high
    repeat (GEFF_A + 2) @(negedge sysclk);
    slave_en = 1'b0;
    m_sel[0] = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!m_gnt[0] && t < 50);
    @(negedge sysclk); m_req[0] = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!s_req && t < 50);
    check("t6_sreq_before", 32'(s_req), 32'(1));
    @(negedge sysclk); reset = 1'b1;
    tick();
    check("t6_sreq", 32'(s_req), 32'(0));
    check("t6_cs_n", 32'(spi_cs_n), 32'(1));
    check("t6_gnt", 32'(m_gnt), 32'(0));
    @(negedge sysclk); m_sel = '0; m_req = '0;
    @(negedge sysclk); reset = 1'b0;
    slave_en = 1'b1;
    grant_log.delete();
    fork
      client_txn(1'b0, 1);
      client_txn(1'b1, 1);
    join
    check("t6_first_after_rst", 32'(log_at(0)), 32'(0));

    // randomised contention
    fork
      begin
        for (int r = 0; r < 12; r++) begin
          repeat ($urandom_range(0, 6)) @(negedge sysclk);
          client_txn(1'b0, int'($urandom_range(0, 3)));
        end
      end
      begin
        for (int r = 0; r < 12; r++) begin
          repeat ($urandom_range(0, 6)) @(negedge sysclk);
          client_txn(1'b1, int'($urandom_range(0, 3)));
        end
      end
    join
    repeat (10) @(negedge sysclk);

    check("mon_gnt_cs", 32'(err_gnt), 32'(0));
    check("mon_sreq", 32'(err_sreq), 32'(0));
    check("mon_ack", 32'(err_ack), 32'(0));
    check("mon_gap", 32'(err_gap), 32'(0));
    check("mon_mq", 32'(err_q), 32'(0));
    check("sb_leftover", 32'(sb_tx.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
